// File: rtl/io_out_pkg.sv
// Register map offsets and default widths shared by the output port slice.
// Latency: none (constants only).
// Backpressure: none (constants only).
package io_out_pkg;

  localparam int IO_DW = 32;
  localparam int IO_AW = 3;

  localparam logic [IO_AW-1:0] OFS_DATA  = 3'd0;
  localparam logic [IO_AW-1:0] OFS_SET   = 3'd1;
  localparam logic [IO_AW-1:0] OFS_CLR   = 3'd2;
  localparam logic [IO_AW-1:0] OFS_TGL   = 3'd3;
  localparam logic [IO_AW-1:0] OFS_BMASK = 3'd4;
  localparam logic [IO_AW-1:0] OFS_BPER  = 3'd5;
  localparam logic [IO_AW-1:0] OFS_STAT  = 3'd6;
  localparam logic [IO_AW-1:0] OFS_RSVD  = 3'd7;

endpackage

// File: rtl/io_blink_timer.sv
// Blink phase generator: phase inverts every 'period' cycles; period 0 holds phase low.
// Latency: phase is a flop; restart clears count and phase at the same edge.
// Backpressure: none, free-running.
module io_blink_timer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] period,
  input  logic          restart,
  output logic          phase
);

  logic [DW-1:0] cnt_q;
  logic          phase_q;

  // Count cycles within a half-period; compare before increment so period=all-ones never wraps.
  always_ff @(posedge clk) begin
    if (rst || restart || (period == '0)) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == period - {{(DW-1){1'b0}}, 1'b1}) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/io_out_port.sv
// Memory-mapped output word register with set/clear/toggle and optional blink (IO_OUT_BLINK_EN).
// Latency: writes visible on outdt at the write edge; ack/rdata one cycle after the access.
// Backpressure: none, accepts an access every cycle and acks each one the next cycle.
module io_out_port
  import io_out_pkg::*;
#(
  parameter int            DW         = IO_DW,
  parameter int            AW         = IO_AW,
  parameter logic [DW-1:0] RST_DATA   = '0,
  parameter logic [DW-1:0] RST_PERIOD = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic [DW-1:0] outdt
);

  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q;
  logic [DW-1:0] bmask_v, bper_v;
  logic          phase_v;

`ifdef IO_OUT_BLINK_EN
  logic [DW-1:0] bmask_q, bper_q;
  logic          bper_wr;
  logic          phase;

  assign bper_wr = we && (addr == OFS_BPER);

  // Blink mask and half-period registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bmask_q <= '0;
      bper_q  <= RST_PERIOD;
    end else begin
      if (we && (addr == OFS_BMASK)) bmask_q <= wdata;
      if (bper_wr)                   bper_q  <= wdata;
    end
  end

  // A period write restarts the timer so a shorter period never strands the count.
  io_blink_timer #(.DW(DW)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .period  (bper_q),
    .restart (bper_wr),
    .phase   (phase)
  );

  assign bmask_v = bmask_q;
  assign bper_v  = bper_q;
  assign phase_v = phase;
`else
  logic unused_rst_period;

  assign unused_rst_period = ^RST_PERIOD;
  assign bmask_v           = '0;
  assign bper_v            = '0;
  assign phase_v           = 1'b0;
`endif

  // Next DATA value from the write decode; non-DATA slots leave it untouched.
  always_comb begin
    data_d = data_q;
    if (we) begin
      case (addr)
        OFS_DATA: data_d = wdata;
        OFS_SET:  data_d = data_q | wdata;
        OFS_CLR:  data_d = data_q & ~wdata;
        OFS_TGL:  data_d = data_q ^ wdata;
        default:  data_d = data_q;
      endcase
    end
  end

  // Read mux sees pre-write register values, so we&re returns the old contents.
  always_comb begin
    rdata_d = '0;
    if (re) begin
      case (addr)
        OFS_DATA, OFS_SET, OFS_CLR, OFS_TGL: rdata_d = data_q;
        OFS_BMASK: rdata_d = bmask_v;
        OFS_BPER:  rdata_d = bper_v;
        OFS_STAT:  rdata_d = {{(DW-1){1'b0}}, phase_v};
        OFS_RSVD:  rdata_d = '0;
        default:   rdata_d = '0;
      endcase
    end
  end

  // DATA register plus the one-cycle ack/rdata response; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RST_DATA;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      ack_q   <= we | re;
      rdata_q <= rdata_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign outdt = data_q ^ (bmask_v & {DW{phase_v}});

endmodule

// File: tb/tb_io_out_port.sv
// Self-checking bench for io_out_port against a cycle-count based reference model.
// Latency: checks ack/rdata/outdt half a cycle after each access edge.
// Backpressure: not applicable; drives one access (or idle) per cycle.
module tb_io_out_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic [31:0] outdt;

  int checks = 0;
  int errors = 0;

  // Reference state: registers plus cycles elapsed since the blink timer last restarted.
  logic [31:0]     m_data, m_bmask, m_bper;
  longint unsigned m_since;
  logic            exp_ack;
  logic [31:0]     exp_rdata, exp_outdt;

  io_out_port dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .outdt (outdt)
  );

  always #5 clk = ~clk;

  // Phase is the parity of how many full half-periods have elapsed since restart.
  function automatic logic m_phase();
`ifdef IO_OUT_BLINK_EN
    if (m_bper == 32'd0) return 1'b0;
    return ((m_since / m_bper) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
`ifdef IO_OUT_BLINK_EN
    if (a == 3'd4) return m_bmask;
    if (a == 3'd5) return m_bper;
    if (a == 3'd6) return {31'd0, m_phase()};
`endif
    if (a <= 3'd3) return m_data;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_outdt();
    return m_phase() ? (m_data ^ m_bmask) : m_data;
  endfunction

  task automatic m_reset();
    m_data  = 32'd0;
    m_bmask = 32'd0;
    m_bper  = 32'd0;
    m_since = 0;
  endtask

  // Drive one access cycle (starting from a negedge), advance the model, return at next negedge.
  task automatic step(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
    logic restart;
    restart   = 1'b0;
    we = w; re = r; addr = a; wdata = d;
    exp_ack   = w | r;
    exp_rdata = r ? m_read(a) : 32'd0;
    if (w) begin
      case (a)
        3'd0: m_data = d;
        3'd1: m_data = m_data + (d & ~m_data);
        3'd2: m_data = m_data - (m_data & d);
        3'd3: m_data = (m_data | d) & ~(m_data & d);
`ifdef IO_OUT_BLINK_EN
        3'd4: m_bmask = d;
        3'd5: begin m_bper = d; restart = 1'b1; end
`endif
        default: ;
      endcase
    end
    @(posedge clk);
    if (restart) m_since = 0;
    else         m_since = m_since + 1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    exp_outdt = m_outdt();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    checks++; if (outdt !== 32'd0) begin errors++; $display("FAIL reset_outdt got=%h exp=0", outdt); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    step(1'b0, 1'b1, 3'd5, 32'd0);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL reset_rd_ack got=%b exp=1", ack); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rd_bper got=%h exp=0", rdata); end
    step(1'b0, 1'b0, 3'd0, 32'd0);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack_drop got=%b exp=0", ack); end
  endtask

  task automatic test_set_clr_tgl();
    step(1'b1, 1'b0, 3'd0, 32'h0000_03FF);
    checks++; if (outdt !== 32'h0000_03FF) begin errors++; $display("FAIL wr_data got=%h exp=000003ff", outdt); end
    step(1'b1, 1'b0, 3'd1, 32'h0000_0400);
    checks++; if (outdt !== 32'h0000_07FF) begin errors++; $display("FAIL set got=%h exp=000007ff", outdt); end
    step(1'b1, 1'b0, 3'd2, 32'h0000_0001);
    checks++; if (outdt !== 32'h0000_07FE) begin errors++; $display("FAIL clr got=%h exp=000007fe", outdt); end
    step(1'b1, 1'b0, 3'd3, 32'h0000_0003);
    checks++; if (outdt !== 32'h0000_07FD) begin errors++; $display("FAIL tgl got=%h exp=000007fd", outdt); end
    step(1'b0, 1'b1, 3'd0, 32'd0);
    checks++; if (rdata !== 32'h0000_07FD || ack !== 1'b1) begin
      errors++; $display("FAIL rd_data got=%h ack=%b exp=000007fd ack=1", rdata, ack);
    end
    for (int a = 1; a <= 3; a++) begin
      step(1'b0, 1'b1, 3'(a), 32'd0);
      checks++; if (rdata !== 32'h0000_07FD) begin errors++; $display("FAIL rd_alias%0d got=%h exp=000007fd", a, rdata); end
    end
    step(1'b0, 1'b1, 3'd7, 32'd0);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rd_rsvd got=%h exp=0", rdata); end
  endtask

  task automatic test_we_re_same();
    step(1'b1, 1'b0, 3'd0, 32'd5);
    step(1'b1, 1'b1, 3'd0, 32'd9);
    checks++; if (rdata !== 32'd5) begin errors++; $display("FAIL wer_rdata got=%h exp=5", rdata); end
    checks++; if (outdt !== 32'd9) begin errors++; $display("FAIL wer_outdt got=%h exp=9", outdt); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wer_ack got=%b exp=1", ack); end
    step(1'b0, 1'b0, 3'd0, 32'd0);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wer_single_ack got=%b exp=0", ack); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i % 2) == 1, 3'd0, 32'(i * 3 + 1));
      checks++; if (ack !== 1'b1 || rdata !== exp_rdata || outdt !== exp_outdt) begin
        errors++; $display("FAIL b2b[%0d] ack=%b rdata=%h outdt=%h exp ack=1 rdata=%h outdt=%h",
                           i, ack, rdata, outdt, exp_rdata, exp_outdt);
      end
    end
  endtask

`ifdef IO_OUT_BLINK_EN
  task automatic test_blink();
    step(1'b1, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b0, 3'd4, 32'd1);
    step(1'b1, 1'b0, 3'd5, 32'd3);
    checks++; if (outdt !== 32'd0) begin errors++; $display("FAIL blink_start got=%h exp=0", outdt); end
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 3'd6, 32'd0);
      checks++; if (outdt !== {31'd0, 1'(((k / 3) % 2) == 1)} || rdata !== exp_rdata) begin
        errors++; $display("FAIL blink[%0d] outdt=%h status=%h exp outdt=%0d status=%h",
                           k, outdt, rdata, (k / 3) % 2, exp_rdata);
      end
    end
    step(1'b0, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b0, 3'd5, 32'd3);
    checks++; if (outdt !== 32'd0) begin errors++; $display("FAIL blink_restart got=%h exp=0", outdt); end
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 3'd6, 32'd0);
      checks++; if (outdt !== exp_outdt || rdata !== exp_rdata) begin
        errors++; $display("FAIL blink_rs[%0d] outdt=%h status=%h exp %h %h", k, outdt, rdata, exp_outdt, exp_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 3'd0, 32'hA5A5_0000);
    step(1'b1, 1'b0, 3'd4, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 3'd5, 32'd1);
    step(1'b0, 1'b0, 3'd0, 32'd0);
    re = 1'b1; addr = 3'd0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; re = 1'b0;
    m_reset();
    checks++; if (ack !== 1'b0 || rdata !== 32'd0 || outdt !== 32'd0) begin
      errors++; $display("FAIL rst_mid ack=%b rdata=%h outdt=%h exp all 0", ack, rdata, outdt);
    end
    step(1'b0, 1'b1, 3'd4, 32'd0);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_bmask got=%h exp=0", rdata); end
  endtask
`else
  task automatic test_no_blink();
    step(1'b1, 1'b0, 3'd0, 32'h1234_5678);
    step(1'b1, 1'b0, 3'd4, 32'h0000_FFFF);
    step(1'b1, 1'b0, 3'd5, 32'd2);
    step(1'b0, 1'b1, 3'd4, 32'd0);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL nb_bmask got=%h exp=0", rdata); end
    step(1'b0, 1'b1, 3'd5, 32'd0);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL nb_bper got=%h exp=0", rdata); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 3'd6, 32'd0);
      checks++; if (outdt !== 32'h1234_5678 || rdata !== 32'd0) begin
        errors++; $display("FAIL nb_const[%0d] outdt=%h status=%h exp 12345678 0", k, outdt, rdata);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic        w, r;
    logic [2:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd5) ? (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 4)))
                      : $urandom;
      step(w, r, a, d);
      checks++; if (ack !== exp_ack || rdata !== exp_rdata || outdt !== exp_outdt) begin
        errors++; $display("FAIL rand[%0d] ack=%b rdata=%h outdt=%h exp ack=%b rdata=%h outdt=%h",
                           i, ack, rdata, outdt, exp_ack, exp_rdata, exp_outdt);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_set_clr_tgl();
    test_we_re_same();
    test_back_to_back();
`ifdef IO_OUT_BLINK_EN
    test_blink();
    test_reset_mid();
`else
    test_no_blink();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
